wave_lut_loader: RTL and testbench
==================================

// Module: wave_lut_loader
// PURPOSE
//   Upstream stage of wave_gen: accepts a byte stream from the host link (valid/ready) and decodes
//   framed commands. Produces the packed waveform LUT bus and the 32-bit clock divider that wave_gen
//   consumes. The LUT is double-buffered, so wave_gen never sees a partially loaded table.
// PARAMETERS
//   LUT_SIZE   4096     width of lut bus in bits; LUT_BYTES = LUT_SIZE/8 samples
//   DIV_RESET  32'd1000 clk_div value after reset
//   TIMEOUT    1000000  max clk cycles between accepted bytes inside a frame before abort
//   CMD_DIV    8'h01    command byte: set divider
//   CMD_LUT    8'h02    command byte: load LUT
// PORTS
//   clk        in   1         system clock, all logic on posedge
//   rst        in   1         asynchronous, active-high reset
//   rx_data    in   8         incoming byte
//   rx_valid   in   1         rx_data valid
//   rx_ready   out  1         loader can accept a byte; transfer when rx_valid && rx_ready
//   lut        out  LUT_SIZE  active table; sample i at lut[8*i+7 -: 8]
//   clk_div    out  32        divider value for wave_gen
//   busy       out  1         high while a frame is in progress (any state except IDLE)
//   load_done  out  1         1-cycle pulse when a new LUT is committed to lut
//   err        out  1         1-cycle pulse on unknown command or frame timeout
// BEHAVIOUR
//   Reset (async, immediate): lut=0, clk_div=DIV_RESET, state=IDLE, counters=0, busy=0,
//     load_done=0, err=0, rx_ready=1. Shadow buffer contents unspecified (never visible).
//   rx_ready=1 in IDLE, DIV and LUT; 0 in COMMIT. A byte is consumed only on rx_valid&&rx_ready.
//   FSM:
//   IDLE: byte==CMD_DIV -> DIV, cnt=0. Byte==CMD_LUT -> LUT, cnt=0. Any other byte: stay IDLE,
//     err pulse next cycle.
//   DIV: 4 bytes, little-endian, into a staging reg; on 4th byte clk_div updates at the same
//     edge (all 32 bits at once, never partially) -> IDLE. No load_done.
//   LUT: byte k (k=0..LUT_BYTES-1) written to shadow[8*k+7 -: 8]; on byte LUT_BYTES-1 -> COMMIT.
//   COMMIT: one cycle; lut <= shadow (whole bus, single edge); load_done=1 that cycle; -> IDLE.
//   Timeout: gap counter cleared on every accepted byte and on entering DIV/LUT; counts while in
//     DIV or LUT. When it reaches TIMEOUT: -> IDLE, err pulse, staged/shadow data discarded
//     (lut and clk_div unchanged).
//   Bytes in a frame are data, never re-decoded as commands (0x01/0x02 payload legal).
//   Counter widths: cnt covers LUT_BYTES-1; the gap counter covers TIMEOUT without wrap.
//   Reset mid-frame aborts the frame; outputs return to the reset values above.
//   err and load_done are registered pulses and never both high in the same cycle.
// TESTING
//   1. Reset, then bytes 01 40 42 0F 00 -> clk_div=32'h000F4240 the cycle after last byte;
//      lut stays 0; no load_done.
//   2. 02 then bytes 0..LUT_BYTES-1 (value=k mod 256) -> single load_done pulse; lut[7:0]=00,
//      lut[15:8]=01, lut[LUT_SIZE-1 -: 8]=FF; lut unchanged before the COMMIT edge.
//   3. Byte 7E in IDLE -> err pulses once; state IDLE; next 01 .. frame decodes normally.
//   4. 02 + 10 bytes, then idle TIMEOUT cycles -> err pulse, busy falls, lut unchanged;
//      a following full LUT frame commits correctly.
//   5. Random rx_valid gaps (< TIMEOUT) during LUT frame -> identical result to test 2;
//      rx_ready low for exactly 1 cycle (COMMIT); byte held during that cycle is not dropped.
//   6. Assert rst mid LUT frame -> lut=0, clk_div=DIV_RESET, busy=0 immediately, asynchronously.

Source files
------------

// File: rtl/wave_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : wave_lut_loader
// Description : Decodes framed host-link commands into the double-buffered
//               waveform LUT bus and the 32-bit clock divider for wave_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_lut_loader #(
    parameter int          LUT_SIZE  = 4096,
    parameter logic [31:0] DIV_RESET = 32'd1000,
    parameter int          TIMEOUT   = 1000000,
    parameter logic [7:0]  CMD_DIV   = 8'h01,
    parameter logic [7:0]  CMD_LUT   = 8'h02
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [LUT_SIZE-1:0] lut,
    output logic [31:0]         clk_div,
    output logic                busy,
    output logic                load_done,
    output logic                err
);

    localparam int c_LUT_BYTES = LUT_SIZE / 8;
    // cnt also walks the 4 divider bytes, so it is never narrower than 2 bits
    localparam int c_CNT_W     = (c_LUT_BYTES > 4) ? $clog2(c_LUT_BYTES) : 2;
    localparam int c_GAP_W     = $clog2(TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_LUT_LAST = c_CNT_W'(c_LUT_BYTES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(3);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DIV    = 2'd1;
    localparam logic [1:0] c_ST_LUT    = 2'd2;
    localparam logic [1:0] c_ST_COMMIT = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_GAP_W-1:0]  r_gap;
    logic [23:0]         r_stage;
    logic [LUT_SIZE-1:0] r_shadow;
    logic [LUT_SIZE-1:0] r_lut;
    logic [31:0]         r_clk_div;
    logic                r_err;
    logic                r_load_done;
    logic                w_err_nxt;
    logic                w_done_nxt;
    logic                w_ready;
    logic                w_accept;
    logic                w_in_frame;
    logic                w_gap_expire;

    assign w_accept     = rx_valid && w_ready;
    assign w_in_frame   = (r_state == c_ST_DIV) || (r_state == c_ST_LUT);
    // Abort on the edge where the idle gap would reach TIMEOUT cycles
    assign w_gap_expire = w_in_frame && !w_accept && (r_gap == c_GAP_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_ready     = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (rx_data == CMD_DIV) begin
                        w_state_nxt = c_ST_DIV;
                    end else if (rx_data == CMD_LUT) begin
                        w_state_nxt = c_ST_LUT;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            c_ST_DIV: begin
                if (w_accept && (r_cnt == c_DIV_LAST)) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_gap_expire) begin
                    w_state_nxt = c_ST_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            c_ST_LUT: begin
                if (w_accept && (r_cnt == c_LUT_LAST)) begin
                    w_state_nxt = c_ST_COMMIT;
                end else if (w_gap_expire) begin
                    w_state_nxt = c_ST_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            c_ST_COMMIT: begin
                w_ready     = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_lut       <= '0;
            r_clk_div   <= DIV_RESET;
            r_err       <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_err       <= w_err_nxt;
            r_load_done <= w_done_nxt;

            if (!w_in_frame) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (!w_in_frame || w_accept || (w_state_nxt != r_state)) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + 1'b1;
            end

            if ((r_state == c_ST_DIV) && w_accept && (r_cnt == c_DIV_LAST)) begin
                r_clk_div <= {rx_data, r_stage};
            end

            if (r_state == c_ST_COMMIT) begin
                r_lut <= r_shadow;
            end
        end
    end

    // Staging and shadow contents are never visible, so they carry no reset
    always_ff @(posedge clk) begin
        if ((r_state == c_ST_DIV) && w_accept) begin
            case (r_cnt[1:0])
                2'd0:    r_stage[7:0]   <= rx_data;
                2'd1:    r_stage[15:8]  <= rx_data;
                2'd2:    r_stage[23:16] <= rx_data;
                default: r_stage        <= r_stage;
            endcase
        end
        if ((r_state == c_ST_LUT) && w_accept) begin
            r_shadow[8*r_cnt +: 8] <= rx_data;
        end
    end

    assign rx_ready  = w_ready;
    assign lut       = r_lut;
    assign clk_div   = r_clk_div;
    assign busy      = (r_state != c_ST_IDLE);
    assign load_done = r_load_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wave_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_lut_loader
// Description : Directed self-checking bench for wave_lut_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_lut_loader;

    localparam int          LUT_SIZE  = 2048;
    localparam int          LUT_BYTES = LUT_SIZE / 8;
    localparam logic [31:0] DIV_RESET = 32'd1000;
    localparam int          TIMEOUT   = 64;

    logic                clk;
    logic                rst;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [LUT_SIZE-1:0] lut;
    logic [31:0]         clk_div;
    logic                busy;
    logic                load_done;
    logic                err;

    logic [LUT_SIZE-1:0] exp_lut;
    int n_total;
    int n_bad;
    int done_cnt;
    int err_cnt;
    int rdy_low_cnt;
    int both_cnt;

    wave_lut_loader #(
        .LUT_SIZE (LUT_SIZE),
        .DIV_RESET(DIV_RESET),
        .TIMEOUT  (TIMEOUT),
        .CMD_DIV  (8'h01),
        .CMD_LUT  (8'h02)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .lut      (lut),
        .clk_div  (clk_div),
        .busy     (busy),
        .load_done(load_done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (load_done) done_cnt++;
            if (err) err_cnt++;
            if (!rx_ready) rdy_low_cnt++;
            if (err && load_done) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller sits 1ns after a posedge; returns 1ns after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int tries;
        rx_data  = b;
        rx_valid = 1'b1;
        tries    = 0;
        while (!rx_ready && tries < 100) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!rx_ready) check("send_ready", {63'b0, rx_ready}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Full LUT frame; inv selects pattern 255-k instead of k, max_gap adds random idles
    task automatic send_lut(input bit inv, input int max_gap);
        logic [7:0] b;
        send_byte(8'h02);
        for (int k = 0; k < LUT_BYTES; k++) begin
            b = inv ? 8'(255 - k) : 8'(k);
            exp_lut[8*k +: 8] = b;
            send_byte(b);
            if (max_gap > 0 && k != LUT_BYTES - 1) idle($urandom_range(max_gap, 0));
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e0;
        int d0;
        int r0;
        int i;
        n_total = 0; n_bad = 0;
        done_cnt = 0; err_cnt = 0; rdy_low_cnt = 0; both_cnt = 0;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        exp_lut = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_lut",      {63'b0, |lut}, 64'd0);
        check("rst_clk_div",  {32'b0, clk_div}, {32'b0, DIV_RESET});
        check("rst_busy",     {63'b0, busy}, 64'd0);
        check("rst_ready",    {63'b0, rx_ready}, 64'd1);
        check("rst_err_done", {62'b0, err, load_done}, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // 1: divider frame
        e0 = err_cnt; d0 = done_cnt;
        send_byte(8'h01);
        check("div_busy", {63'b0, busy}, 64'd1);
        send_byte(8'h40); send_byte(8'h42); send_byte(8'h0F);
        check("div_no_partial", {32'b0, clk_div}, {32'b0, DIV_RESET});
        send_byte(8'h00);
        idle(0);
        check("div_value", {32'b0, clk_div}, 64'h000F4240);
        check("div_idle",  {63'b0, busy}, 64'd0);
        idle(2);
        check("div_lut_zero", {63'b0, |lut}, 64'd0);
        check("div_no_done",  64'(done_cnt - d0), 64'd0);
        check("div_no_err",   64'(err_cnt - e0), 64'd0);

        // 2: LUT frame, back to back
        d0 = done_cnt;
        send_byte(8'h02);
        for (int k = 0; k < LUT_BYTES - 1; k++) begin
            exp_lut[8*k +: 8] = 8'(k);
            send_byte(8'(k));
        end
        check("lut_pre_last", {63'b0, |lut}, 64'd0);
        exp_lut[LUT_SIZE-1 -: 8] = 8'(LUT_BYTES - 1);
        send_byte(8'(LUT_BYTES - 1));
        rx_valid = 1'b0;
        check("commit_ready", {63'b0, rx_ready}, 64'd0);
        check("commit_lut_old", {63'b0, |lut}, 64'd0);
        check("commit_done_low", {63'b0, load_done}, 64'd0);
        @(posedge clk); #1;
        check("lut_done_pulse", {63'b0, load_done}, 64'd1);
        check("lut_b0",  {56'b0, lut[7:0]}, 64'h00);
        check("lut_b1",  {56'b0, lut[15:8]}, 64'h01);
        check("lut_top", {56'b0, lut[LUT_SIZE-1 -: 8]}, 64'hFF);
        check("lut_full", {63'b0, lut == exp_lut}, 64'd1);
        idle(3);
        check("lut_done_count", 64'(done_cnt - d0), 64'd1);

        // 3: unknown command in IDLE
        e0 = err_cnt;
        send_byte(8'h7E);
        rx_valid = 1'b0;
        check("bad_cmd_err",  {63'b0, err}, 64'd1);
        check("bad_cmd_idle", {63'b0, busy}, 64'd0);
        idle(3);
        check("bad_cmd_once", 64'(err_cnt - e0), 64'd1);
        send_byte(8'h01);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        idle(1);
        check("div_after_err", {32'b0, clk_div}, 64'h12345678);

        // 4: timeout mid LUT frame
        e0 = err_cnt;
        send_byte(8'h02);
        for (int k = 0; k < 10; k++) send_byte(8'hA0 + 8'(k));
        rx_valid = 1'b0;
        i = 0;
        while (i < TIMEOUT + 5) begin
            @(posedge clk); #1;
            i++;
            if (err) break;
        end
        check("timeout_cycles", 64'(i), 64'(TIMEOUT));
        check("timeout_idle", {63'b0, busy}, 64'd0);
        check("timeout_lut_kept", {63'b0, lut == exp_lut}, 64'd1);
        check("timeout_div_kept", {32'b0, clk_div}, 64'h12345678);
        idle(2);
        check("timeout_err_once", 64'(err_cnt - e0), 64'd1);
        d0 = done_cnt;
        send_lut(1'b1, 0);
        idle(3);
        check("reload_full", {63'b0, lut == exp_lut}, 64'd1);
        check("reload_done", 64'(done_cnt - d0), 64'd1);

        // 5: random gaps, then a command byte held across COMMIT
        d0 = done_cnt; r0 = rdy_low_cnt; e0 = err_cnt;
        send_lut(1'b0, 3);
        send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(2);
        check("gap_lut_full", {63'b0, lut == exp_lut}, 64'd1);
        check("gap_top", {56'b0, lut[LUT_SIZE-1 -: 8]}, 64'hFF);
        check("gap_done", 64'(done_cnt - d0), 64'd1);
        check("gap_ready_low", 64'(rdy_low_cnt - r0), 64'd1);
        check("held_byte_div", {32'b0, clk_div}, 64'hDDCCBBAA);
        check("gap_no_err", 64'(err_cnt - e0), 64'd0);

        // 6: asynchronous reset mid frame
        send_byte(8'h02);
        for (int k = 0; k < 20; k++) send_byte(8'(k + 3));
        #2 rst = 1'b1;
        #1;
        check("arst_lut", {63'b0, |lut}, 64'd0);
        check("arst_div", {32'b0, clk_div}, {32'b0, DIV_RESET});
        check("arst_busy", {63'b0, busy}, 64'd0);
        check("arst_ready", {63'b0, rx_ready}, 64'd1);
        rx_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        idle(2);
        check("never_both", 64'(both_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
